// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the RV32 ID/EX control path.
// Holds the opcode constants, the 2-bit ALU-op encoding, the packed
// control bundle carried from ID into EX, the bubble constant and the
// ID-stage FSM state type.
package pipe_ctrl_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  // Width of the rd field inside the bundle (RV32 register index).
  localparam int CTRL_RD_W = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic                 valid;
    alu_op_e              alu_op;
    logic                 alu_src;
    logic                 branch;
    logic                 jump;
    logic                 jalr;
    logic                 lui;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic [CTRL_RD_W-1:0] rd;
    logic                 illegal;
  } ctrl_bundle_t;

  // A bubble is the all-zero bundle: not valid, no side effects.
  localparam ctrl_bundle_t CTRL_BUBBLE = ctrl_bundle_t'('0);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } id_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder.
// Ports:
//   instr_i     : instruction word
//   ctrl_o      : decoded control bundle (valid=1, rd taken from instr[11:7])
//   rs1_o/rs2_o : source register indices
//   rs1_used_o  : instruction reads rs1
//   rs2_used_o  : instruction reads rs2
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]      instr_i,
  output ctrl_bundle_t         ctrl_o,
  output logic [CTRL_RD_W-1:0] rs1_o,
  output logic [CTRL_RD_W-1:0] rs2_o,
  output logic                 rs1_used_o,
  output logic                 rs2_used_o
);

  // funct/immediate bits are not needed for control decode.
  logic unused_bits;
  assign unused_bits = ^{instr_i[XLEN-1:25], instr_i[14:12]};

  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];

  always_comb begin
    ctrl_o       = CTRL_BUBBLE;
    ctrl_o.valid = 1'b1;
    ctrl_o.rd    = instr_i[11:7];
    rs1_used_o   = 1'b0;
    rs2_used_o   = 1'b0;
    case (instr_i[6:0])
      OPC_R: begin
        ctrl_o.alu_op    = ALU_RTYPE;
        ctrl_o.reg_write = 1'b1;
        rs1_used_o       = 1'b1;
        rs2_used_o       = 1'b1;
      end
      OPC_ADDI: begin
        ctrl_o.alu_op    = ALU_ITYPE;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        rs1_used_o       = 1'b1;
      end
      OPC_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        rs1_used_o        = 1'b1;
      end
      OPC_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        rs1_used_o       = 1'b1;
        rs2_used_o       = 1'b1;
      end
      OPC_BEQ: begin
        ctrl_o.alu_op = ALU_SUB;
        ctrl_o.branch = 1'b1;
        rs1_used_o    = 1'b1;
        rs2_used_o    = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.jalr      = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        rs1_used_o       = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.lui       = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      default: begin
        // Still advances as valid so the trap logic downstream sees it.
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_control.sv
// ID-stage control unit: decodes the IF/ID instruction and registers the
// EX-side half of the ID/EX pipeline register. Detects load-use hazards
// (inserting LOAD_USE_STALLS bubbles, legal range 1..3), and kills the ID
// instruction on a taken branch/jump flush.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   instr_i           : instruction held in IF/ID
//   instr_valid_i     : IF/ID holds a real instruction
//   flush_i           : taken branch/jump resolved in EX
//   stall_o           : combinational; freeze PC and IF/ID
//   ex_*_o            : registered EX control bundle
module id_ex_control
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   instr_i,
  input  logic              instr_valid_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [1:0]        ex_alu_op_o,
  output logic              ex_alu_src_o,
  output logic              ex_branch_o,
  output logic              ex_jump_o,
  output logic              ex_jalr_o,
  output logic              ex_lui_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_to_reg_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_illegal_o
);

  // Extra stall cycles spent in STALL after the first (hazard) cycle.
  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALLS - 1);

  ctrl_bundle_t         dec_ctrl;
  logic [CTRL_RD_W-1:0] dec_rs1;
  logic [CTRL_RD_W-1:0] dec_rs2;
  logic                 dec_rs1_used;
  logic                 dec_rs2_used;

  ctrl_bundle_t ex_q, ex_d;
  id_state_e    state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         hazard;
  logic         stall;

  ctrl_decode #(.XLEN(XLEN)) u_decode (
    .instr_i    (instr_i),
    .ctrl_o     (dec_ctrl),
    .rs1_o      (dec_rs1),
    .rs2_o      (dec_rs2),
    .rs1_used_o (dec_rs1_used),
    .rs2_used_o (dec_rs2_used)
  );

  // A load writing x0 never creates a dependency.
  assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & instr_valid_i &
                  ((dec_rs1_used & (dec_rs1 == ex_q.rd)) |
                   (dec_rs2_used & (dec_rs2 == ex_q.rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    ex_d    = instr_valid_i ? dec_ctrl : CTRL_BUBBLE;
    if (flush_i) begin
      ex_d    = CTRL_BUBBLE;
      state_d = ST_RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            stall   = 1'b1;
            ex_d    = CTRL_BUBBLE;
            cnt_d   = STALL_RELOAD;
            state_d = (STALL_RELOAD != 2'd0) ? ST_STALL : ST_RUN;
          end
        end
        ST_STALL: begin
          stall = 1'b1;
          ex_d  = CTRL_BUBBLE;
          // No hazard re-check on exit: the load has already left EX.
          if (cnt_q <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= CTRL_BUBBLE;
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_o         = stall;
  assign ex_valid_o      = ex_q.valid;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_branch_o     = ex_q.branch;
  assign ex_jump_o       = ex_q.jump;
  assign ex_jalr_o       = ex_q.jalr;
  assign ex_lui_o        = ex_q.lui;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_rd_o         = REG_AW'(ex_q.rd);
  assign ex_illegal_o    = ex_q.illegal;

endmodule

// File: doc/id_ex_control.md
Name: id_ex_control

Overview:
- Second-generation ID-stage control unit for the 5-stage RV32 pipeline.
- Decodes the IF/ID instruction into a control bundle and registers it as the EX-side half of the ID/EX pipeline register.
- Adds load-use hazard detection with a parametrised stall length, bubble injection, branch/jump flush, an extended opcode set (JAL, JALR, LUI) and illegal-opcode flagging.
- Feeds the EX/MEM/WB control path; stall_o freezes PC and IF/ID.

Parameters:
- XLEN, 32, instruction width.
- REG_AW, 5, register-address width.
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1 with MEM->EX forwarding, 2 without); legal range 1..3.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- instr_i  input  XLEN  instruction held in IF/ID.
- instr_valid_i  input  1  IF/ID holds a real instruction (0 = bubble).
- flush_i  input  1  branch/jump resolved taken in EX; kill the ID instruction.
- stall_o  output  1  combinational; hold PC and IF/ID this cycle.
- ex_valid_o  output  1  EX control bundle is a real instruction.
- ex_alu_op_o  output  2  00 add, 01 sub/compare, 10 R-type funct decode, 11 I-type funct decode.
- ex_alu_src_o  output  1  1 = immediate operand B.
- ex_branch_o, ex_jump_o, ex_jalr_o, ex_lui_o  output  1 each  control-flow / upper-immediate select.
- ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o  output  1 each  memory/WB control.
- ex_rd_o  output  REG_AW  destination register.
- ex_illegal_o  output  1  instruction had an unsupported opcode.

Behaviour:
- Reset (async, rst_n=0): every ex_* output is 0, FSM in RUN, stall counter 0; stall_o=0. Reset mid-stall aborts the stall.
- Decode (combinational, opcode instr_i[6:0]):
  - R 0110011: op10, src0, reg_write.
  - ADDI-class 0010011: op11, src1, reg_write.
  - LW 0000011: op00, src1, mem_read, reg_write, mem_to_reg.
  - SW 0100011: op00, src1, mem_write.
  - BEQ 1100011: op01, src0, branch.
  - JAL 1101111: jump, reg_write.
  - JALR 1100111: jump, jalr, src1, reg_write.
  - LUI 0110111: lui, src1, reg_write.
  - Unlisted controls are 0; no X values anywhere.
  - Any other opcode: all controls 0, illegal=1. The instruction still advances with valid=1 so the trap logic sees it.
- Source use:
  - rs1 (instr[19:15]) is used by R, ADDI, LW, SW, BEQ, JALR.
  - rs2 (instr[24:20]) is used by R, SW, BEQ.
- Hazard condition: ex_valid_o & ex_mem_read_o & ex_rd_o!=0 & instr_valid_i & (used rs1 == ex_rd_o or used rs2 == ex_rd_o).
- FSM states: RUN, STALL.
  - RUN with hazard: stall_o=1, register a bubble (ex_valid_o and all ex controls 0), counter=LOAD_USE_STALLS-1. Go to STALL if the counter is nonzero, else stay in RUN.
  - STALL: stall_o=1, bubble, decrement counter; return to RUN when the counter reaches 0 after the decrement.
  - Hazard re-check after STALL is not needed: the load has left EX.
- Normal RUN without hazard: on each rising edge, decoded bundle -> ex_* registers; ex_valid_o=instr_valid_i. If instr_valid_i=0, the bundle is forced to 0.
- Flush priority: flush_i=1 overrides everything.
  - Next ex_* is a bubble, FSM goes to RUN, counter is cleared, stall_o=0 that cycle.
  - flush and hazard in the same cycle: flush wins.
- Latency: 1 cycle from instr_i to ex_* outputs.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - opcode localparams.
  - alu_op enum (2 bits).
  - packed struct ctrl_bundle_t holding all ex_* fields, plus the CTRL_BUBBLE constant.
- One natural sub-module: ctrl_decode (pure combinational opcode -> ctrl_bundle_t + rs-use flags), reusable by a later superscalar decoder.
- The FSM, counter and ID/EX register stay in id_ex_control.

Test Plan:
- Reset mid-stream: assert rst_n=0 while ex_valid_o=1 -> all ex_* 0 and stall_o=0 immediately (asynchronous, no clock edge needed).
- Decode sweep, one instruction per cycle:
  - 0x002081B3 (ADD x3,x1,x2) -> op=10, reg_write=1, rd=3.
  - 0x0000A283 (LW x5,0(x1)) -> mem_read=1, mem_to_reg=1, rd=5.
  - JAL/JALR/LUI -> the matching flags set.
- Load-use, LOAD_USE_STALLS=1: LW x5 then 0x00228333 (ADD x6,x5,x2) -> stall_o=1 for exactly 1 cycle, one bubble, then ADD in EX with rd=6. Rerun with LOAD_USE_STALLS=2 -> 2 stall cycles, 2 bubbles.
- No false hazard: 0x0000A003 (LW x0) then ADD x6,x0,x2 -> stall_o stays 0. LW x5 then ADDI x7,x1,5 -> no stall.
- Flush during stall: LOAD_USE_STALLS=2, assert flush_i in the first stall cycle -> stall_o=0 that cycle, next ex bundle is a bubble, FSM back in RUN.
- Illegal opcode: 0xFFFFFFFF -> ex_valid_o=1, ex_illegal_o=1, all other controls 0.
